dma_register_responder: RTL and testbench

// - AXI-lite slave exposing the DMA control registers (CR 0x30, SR 0x34, DA 0x48, LENGTH 0x58) that the DMA master programs.
// - Turns register writes into a one-cycle transfer_start command carrying destination address and length.
// - Reports completion through the SR IOC flag and an irq output.
// - Sits on the control bus as the target of the DMA manager; also used as a simulation stand-in for a vendor DMA core.

---
 rtl/dma_regs_pkg.sv | 33 +++
 rtl/dma_register_responder_if.sv | 35 +++
 rtl/axi_lite_slave_frontend.sv | 108 ++++++++++
 rtl/dma_register_responder.sv | 152 +++++++++++++++
 tb/tb_dma_register_responder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_regs_pkg.sv
// DMA control register map: offsets, bit positions, AXI response codes, byte-strobe merge.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package dma_regs_pkg;

    localparam logic [7:0] CR_OFS     = 8'h30;
    localparam logic [7:0] SR_OFS     = 8'h34;
    localparam logic [7:0] DA_OFS     = 8'h48;
    localparam logic [7:0] LENGTH_OFS = 8'h58;

    localparam int RS_BIT     = 0;
    localparam int IOC_EN_BIT = 12;
    localparam int HALTED_BIT = 0;
    localparam int IDLE_BIT   = 1;
    localparam int IOC_BIT    = 12;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    // Replace only the bytes whose write strobe is set.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dma_register_responder_if.sv
// AXI-lite bundle (AW/W/B/AR/R) between the DMA manager and the register responder.
// Latency: none (wires only).
// Backpressure: standard valid/ready on every channel.
interface dma_register_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_slave_frontend.sv
// AXI-lite slave handshake engine: 1-entry AW and W holds, B and R response registers.
// Latency: register strobe 1 cycle after both holds fill (BVALID same cycle); RVALID 1 cycle after AR.
// Backpressure: a hold's READY drops while full or while B pending; ARREADY drops while R pending.
module axi_lite_slave_frontend
    import dma_regs_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    dma_register_responder_if.slave   axi,
    output logic                      wr_en,
    output logic [OFFSET_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [DATA_WIDTH/8-1:0]   wr_strb,
    input  logic                      wr_err,
    output logic                      rd_en,
    output logic [OFFSET_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    input  logic                      rd_err
);
    logic                    ready_en;
    logic                    aw_full;
    logic                    w_full;
    logic                    b_pending;
    logic                    r_pending;
    logic [OFFSET_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [DATA_WIDTH/8-1:0] w_strb_q;
    resp_t                   b_resp_q;
    resp_t                   r_resp_q;
    logic [DATA_WIDTH-1:0]   r_data_q;
    logic                    aw_rdy;
    logic                    w_rdy;
    logic                    ar_rdy;

    // Only the low offset bits are ever decoded, so only those are held.
    assign aw_rdy = ready_en & ~aw_full & ~b_pending;
    assign w_rdy  = ready_en & ~w_full & ~b_pending;
    assign ar_rdy = ready_en & ~r_pending;

    assign axi.awready = aw_rdy;
    assign axi.wready  = w_rdy;
    assign axi.arready = ar_rdy;
    assign axi.bvalid  = b_pending;
    assign axi.bresp   = b_resp_q;
    assign axi.rvalid  = r_pending;
    assign axi.rdata   = r_data_q;
    assign axi.rresp   = r_resp_q;

    assign wr_en   = aw_full & w_full & ~b_pending;
    assign wr_addr = aw_addr_q;
    assign wr_data = w_data_q;
    assign wr_strb = w_strb_q;

    assign rd_en   = axi.arvalid & ar_rdy;
    assign rd_addr = axi.araddr[OFFSET_WIDTH-1:0];

    // Write side: fill holds independently, fire the register strobe once both are full, then hold B.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_en  <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_pending <= 1'b0;
            b_resp_q  <= OKAY;
        end else begin
            ready_en <= 1'b1;
            if (axi.awvalid && aw_rdy) begin
                aw_full   <= 1'b1;
                aw_addr_q <= axi.awaddr[OFFSET_WIDTH-1:0];
            end
            if (axi.wvalid && w_rdy) begin
                w_full   <= 1'b1;
                w_data_q <= axi.wdata;
                w_strb_q <= axi.wstrb;
            end
            if (wr_en) begin
                aw_full   <= 1'b0;
                w_full    <= 1'b0;
                b_pending <= 1'b1;
                b_resp_q  <= wr_err ? SLVERR : OKAY;
            end else if (b_pending && axi.bready) begin
                b_pending <= 1'b0;
            end
        end
    end

    // Read side: capture the register view on AR and hold it until RREADY.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= OKAY;
        end else if (rd_en) begin
            r_pending <= 1'b1;
            r_data_q  <= rd_data;
            r_resp_q  <= rd_err ? SLVERR : OKAY;
        end else if (r_pending && axi.rready) begin
            r_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/dma_register_responder.sv
// DMA control register block (CR/SR/DA/LENGTH) that launches transfers and reports completion.
// Latency: transfer_start and BVALID in the same cycle, 1 cycle after the LENGTH write is complete; irq 1 cycle after IOC&IOC_EN.
// Backpressure: AXI-lite valid/ready via the frontend; transfer_start/transfer_done are unthrottled pulses.
module dma_register_responder
    import dma_regs_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 8,
    parameter int LENGTH_WIDTH = 26
) (
    input  logic                      clock,
    input  logic                      reset,
    dma_register_responder_if.slave   axi,
    input  logic                      transfer_done,
    output logic                      transfer_start,
    output logic [ADDR_WIDTH-1:0]     transfer_addr,
    output logic [LENGTH_WIDTH-1:0]   transfer_size,
    output logic                      busy,
    output logic                      irq
);
    logic                    wr_en;
    logic [OFFSET_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic                    wr_err;
    logic                    rd_en;
    logic [OFFSET_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_err;

    logic                    rs;
    logic                    ioc_en;
    logic                    ioc;
    logic [31:0]             da;
    logic [LENGTH_WIDTH-1:0] length;

    logic [31:0] cr_view;
    logic [31:0] sr_view;
    logic [31:0] len_view;
    logic [31:0] wr_merged;
    logic        busy_after_done;
    logic        wr_ok;
    logic        wr_cr;
    logic        wr_sr;
    logic        wr_da;
    logic        wr_len;
    logic        start_now;

    axi_lite_slave_frontend #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_frontend (
        .clock   (clock),
        .reset   (reset),
        .axi     (axi),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .wr_err  (wr_err),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_err  (rd_err)
    );

    function automatic logic is_mapped(input logic [OFFSET_WIDTH-1:0] ofs);
        return (ofs == OFFSET_WIDTH'(CR_OFS)) || (ofs == OFFSET_WIDTH'(SR_OFS)) ||
               (ofs == OFFSET_WIDTH'(DA_OFS)) || (ofs == OFFSET_WIDTH'(LENGTH_OFS));
    endfunction

    function automatic logic [31:0] sel_reg(input logic [OFFSET_WIDTH-1:0] ofs,
                                            input logic [31:0] cr_v, input logic [31:0] sr_v,
                                            input logic [31:0] da_v, input logic [31:0] len_v);
        logic [31:0] v;
        v = '0;
        if (ofs == OFFSET_WIDTH'(CR_OFS))     v = cr_v;
        if (ofs == OFFSET_WIDTH'(SR_OFS))     v = sr_v;
        if (ofs == OFFSET_WIDTH'(DA_OFS))     v = da_v;
        if (ofs == OFFSET_WIDTH'(LENGTH_OFS)) v = len_v;
        return v;
    endfunction

    // Register views as seen on the bus; unimplemented bits read zero.
    always_comb begin
        cr_view = '0;
        cr_view[RS_BIT]     = rs;
        cr_view[IOC_EN_BIT] = ioc_en;
        sr_view = '0;
        sr_view[HALTED_BIT] = ~rs;
        sr_view[IDLE_BIT]   = ~busy;
        sr_view[IOC_BIT]    = ioc;
        len_view = 32'(length);
    end

    // A done arriving with a write retires first, so the write sees the post-done busy state.
    assign busy_after_done = busy & ~transfer_done;
    assign wr_merged = apply_strb(sel_reg(wr_addr, cr_view, sr_view, da, len_view),
                                  wr_data[31:0], wr_strb[3:0]);
    assign wr_len    = (wr_addr == OFFSET_WIDTH'(LENGTH_OFS));
    assign wr_cr     = (wr_addr == OFFSET_WIDTH'(CR_OFS));
    assign wr_sr     = (wr_addr == OFFSET_WIDTH'(SR_OFS));
    assign wr_da     = (wr_addr == OFFSET_WIDTH'(DA_OFS));
    assign wr_err    = ~is_mapped(wr_addr) | (wr_len & busy_after_done);
    assign wr_ok     = wr_en & ~wr_err;
    assign start_now = wr_ok & wr_len & rs & (wr_merged[LENGTH_WIDTH-1:0] != '0);

    assign rd_err  = ~is_mapped(rd_addr);
    assign rd_data = DATA_WIDTH'(sel_reg(rd_addr, cr_view, sr_view, da, len_view));

    // Register file, transfer launch/completion tracking and the registered interrupt.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rs             <= 1'b0;
            ioc_en         <= 1'b0;
            ioc            <= 1'b0;
            da             <= '0;
            length         <= '0;
            busy           <= 1'b0;
            irq            <= 1'b0;
            transfer_start <= 1'b0;
            transfer_addr  <= '0;
            transfer_size  <= '0;
        end else begin
            transfer_start <= start_now;
            irq            <= ioc & ioc_en;
            busy           <= start_now | busy_after_done;
            if (wr_ok && wr_cr) begin
                rs     <= wr_merged[RS_BIT];
                ioc_en <= wr_merged[IOC_EN_BIT];
            end
            if (wr_ok && wr_da) begin
                da <= wr_merged;
            end
            if (wr_ok && wr_len) begin
                length <= wr_merged[LENGTH_WIDTH-1:0];
            end
            if (start_now) begin
                transfer_addr <= ADDR_WIDTH'(da);
                transfer_size <= wr_merged[LENGTH_WIDTH-1:0];
            end
            // Completion beats a simultaneous write-1-to-clear.
            if (busy && transfer_done) begin
                ioc <= 1'b1;
            end else if (wr_ok && wr_sr && wr_strb[IOC_BIT/8] && wr_data[IOC_BIT]) begin
                ioc <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_register_responder.sv
// Directed and randomized bench for dma_register_responder against a register-level model.
// Latency: not applicable.
// Backpressure: exercises BREADY/RREADY stalls and split AW/W presentation.
module tb_dma_register_responder;

    logic        clk;
    logic        rst_n;
    logic        transfer_done;
    logic        transfer_start;
    logic [31:0] transfer_addr;
    logic [25:0] transfer_size;
    logic        busy;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    dma_register_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifc ();

    dma_register_responder #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .OFFSET_WIDTH (8),
        .LENGTH_WIDTH (26)
    ) dut (
        .clock          (clk),
        .reset          (rst_n),
        .axi            (ifc),
        .transfer_done  (transfer_done),
        .transfer_start (transfer_start),
        .transfer_addr  (transfer_addr),
        .transfer_size  (transfer_size),
        .busy           (busy),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the register block should hold after each bus event.
    logic        m_rs, m_ioc_en, m_ioc, m_busy;
    logic [31:0] m_da;
    logic [25:0] m_len;
    logic [31:0] m_exp_addr;
    logic [25:0] m_exp_size;

    // Observers sampled a little after each rising edge.
    int          start_cnt = 0;
    int          bv_rises  = 0;
    logic        bv_prev   = 1'b0;
    logic [31:0] last_addr = '0;
    logic [25:0] last_size = '0;

    always @(posedge clk) begin
        #2;
        if (transfer_start) begin
            start_cnt++;
            last_addr = transfer_addr;
            last_size = transfer_size;
        end
        if (ifc.bvalid && !bv_prev) bv_rises++;
        bv_prev = ifc.bvalid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_rs = 0; m_ioc_en = 0; m_ioc = 0; m_busy = 0; m_da = 0; m_len = 0;
        m_exp_addr = 0; m_exp_size = 0;
    endfunction

    function automatic logic m_mapped(input logic [7:0] ofs);
        return ofs inside {8'h30, 8'h34, 8'h48, 8'h58};
    endfunction

    function automatic logic [31:0] m_view(input logic [7:0] ofs);
        case (ofs)
            8'h30:   return {19'b0, m_ioc_en, 11'b0, m_rs};
            8'h34:   return {19'b0, m_ioc, 10'b0, !m_busy, !m_rs};
            8'h48:   return m_da;
            8'h58:   return {6'b0, m_len};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_done();
        if (m_busy) begin
            m_busy = 0;
            m_ioc  = 1;
        end
    endfunction

    function automatic void m_write(input logic [7:0] ofs, input logic [31:0] data,
                                    input logic [3:0] strb, output logic [1:0] resp,
                                    output logic start);
        logic [31:0] old_v, nw;
        old_v = m_view(ofs);
        for (int b = 0; b < 4; b++) nw[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old_v[b*8 +: 8];
        resp  = 2'b00;
        start = 0;
        if (!m_mapped(ofs)) begin
            resp = 2'b10;
        end else begin
            case (ofs)
                8'h30: begin m_rs = nw[0]; m_ioc_en = nw[12]; end
                8'h34: if (strb[1] && data[12]) m_ioc = 0;
                8'h48: m_da = nw;
                8'h58: begin
                    if (m_busy) begin
                        resp = 2'b10;
                    end else begin
                        m_len = nw[25:0];
                        if (m_rs && m_len != 0) begin
                            start = 1;
                            m_busy = 1;
                            m_exp_addr = m_da;
                            m_exp_size = m_len;
                        end
                    end
                end
                default: ;
            endcase
        end
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic with_done);
        logic [1:0] er;
        logic       es, was, ag, wg;
        int         n, s0;
        s0 = start_cnt;
        @(negedge clk);
        ifc.awaddr = addr; ifc.awvalid = 1;
        ifc.wdata = data; ifc.wstrb = strb; ifc.wvalid = 1;
        ifc.bready = 1;
        n = 0;
        while ((ifc.awvalid || ifc.wvalid) && n < 20) begin
            ag = ifc.awvalid & ifc.awready;
            wg = ifc.wvalid & ifc.wready;
            @(negedge clk);
            n++;
            if (ag) ifc.awvalid = 0;
            if (wg) ifc.wvalid = 0;
        end
        check("wr_accept", 32'({ifc.awvalid, ifc.wvalid}), 32'h0);
        ifc.awvalid = 0;
        ifc.wvalid  = 0;
        // This is the update cycle: both holds are full.
        was = m_busy;
        if (with_done) begin
            transfer_done = 1;
            m_done();
        end
        m_write(addr[7:0], data, strb, er, es);
        if (with_done && was) m_ioc = 1;
        n = 0;
        do begin
            @(negedge clk);
            transfer_done = 0;
            n++;
        end while (!ifc.bvalid && n < 20);
        check("bvalid", 32'(ifc.bvalid), 32'h1);
        check("bresp", 32'(ifc.bresp), 32'(er));
        check("start_pulses", 32'(start_cnt - s0), 32'(es));
        if (es) begin
            check("start_addr", last_addr, m_exp_addr);
            check("start_size", 32'(last_size), 32'(m_exp_size));
        end
        check("busy_after_wr", 32'(busy), 32'(m_busy));
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        @(negedge clk);
        ifc.araddr = addr; ifc.arvalid = 1; ifc.rready = 1;
        n = 0;
        while (!ifc.arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ifc.arvalid = 0;
        check("rvalid", 32'(ifc.rvalid), 32'h1);
        data = ifc.rdata;
        resp = ifc.rresp;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] addr);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check({tag, ".data"}, d, m_view(addr[7:0]));
        check({tag, ".resp"}, 32'(r), m_mapped(addr[7:0]) ? 32'h0 : 32'h2);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        transfer_done = 1;
        m_done();
        @(negedge clk);
        transfer_done = 0;
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
        check({tag, ".irq"}, 32'(irq), 32'(m_ioc & m_ioc_en));
    endtask

    initial begin
        logic [31:0] d, addr, data, hi;
        logic [1:0]  r, er;
        logic [7:0]  ofs;
        logic [3:0]  strb;
        logic        es;
        int          n, bv0, op, sel;

        rst_n = 0;
        transfer_done = 0;
        ifc.awaddr = 0; ifc.awvalid = 0; ifc.wdata = 0; ifc.wstrb = 0; ifc.wvalid = 0;
        ifc.bready = 0; ifc.araddr = 0; ifc.arvalid = 0; ifc.rready = 0;
        m_reset();

        // Reset state and ready release timing.
        repeat (3) @(negedge clk);
        check("rst.awready", 32'(ifc.awready), 32'h0);
        check("rst.arready", 32'(ifc.arready), 32'h0);
        check("rst.outputs", 32'({transfer_start, busy, irq, ifc.bvalid, ifc.rvalid}), 32'h0);
        check("rst.addr", transfer_addr, 32'h0);
        rst_n = 1;
        #1;
        check("rel.wready", 32'(ifc.wready), 32'h0);
        @(negedge clk);
        check("rel+1.awready", 32'(ifc.awready), 32'h1);
        check("rel+1.wready", 32'(ifc.wready), 32'h1);
        check("rel+1.arready", 32'(ifc.arready), 32'h1);
        check_reg("rst.sr", 32'h34);
        check("rst.sr_value", m_view(8'h34), 32'h0000_0003);
        check_reg("rst.cr", 32'h30);
        check_reg("rst.da", 32'h48);
        check_reg("rst.len", 32'h58);

        // Program and launch a transfer.
        axi_write(32'h30, 32'h1001, 4'hF, 0);
        axi_write(32'h48, 32'h1000_0000, 4'hF, 0);
        axi_write(32'h58, 32'h400, 4'hF, 0);
        check("launch.addr", last_addr, 32'h1000_0000);
        check("launch.size", 32'(last_size), 32'h400);
        check_reg("busy.sr", 32'h34);

        // Completion, interrupt, W1C.
        pulse_done();
        check_status("done");
        check_reg("done.sr", 32'h34);
        axi_write(32'h34, 32'h1000, 4'hF, 0);
        check_status("w1c");
        check_reg("w1c.sr", 32'h34);

        // Error responses.
        axi_write(32'h58, 32'h100, 4'hF, 0);
        axi_write(32'h58, 32'h20, 4'hF, 0);
        check_reg("busy_len.len", 32'h58);
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0);
        check_reg("unmapped.rd", 32'h40);

        // Done coincident with a LENGTH write: may restart immediately.
        axi_write(32'h58, 32'h80, 4'hF, 1);
        axi_write(32'h34, 32'h1000, 4'hF, 0);
        check_reg("ioc_clr.sr", 32'h34);
        // Done coincident with IOC W1C: set wins.
        axi_write(32'h34, 32'h1000, 4'hF, 1);
        check_reg("ioc_race.sr", 32'h34);
        check_status("ioc_race");

        // Clearing RS while busy does not abort.
        axi_write(32'h58, 32'h40, 4'hF, 0);
        axi_write(32'h30, 32'h1000, 4'hF, 0);
        check_status("rs_clear");
        pulse_done();
        check_status("rs_clear_done");
        axi_write(32'h30, 32'h1001, 4'hF, 0);

        // W three cycles ahead of AW, BREADY held low five cycles.
        bv0 = bv_rises;
        data = 32'hCAFE_0001;
        @(negedge clk);
        ifc.bready = 0;
        ifc.wdata = data; ifc.wstrb = 4'hF; ifc.wvalid = 1;
        check("split.wready", 32'(ifc.wready), 32'h1);
        @(negedge clk);
        ifc.wvalid = 0;
        check("split.wready_full", 32'(ifc.wready), 32'h0);
        repeat (2) @(negedge clk);
        ifc.awaddr = 32'h48; ifc.awvalid = 1;
        check("split.awready", 32'(ifc.awready), 32'h1);
        @(negedge clk);
        ifc.awvalid = 0;
        m_write(8'h48, data, 4'hF, er, es);
        n = 0;
        while (!ifc.bvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("stall.bvalid", 32'(ifc.bvalid), 32'h1);
            check("stall.bresp", 32'(ifc.bresp), 32'(er));
            check("stall.readies", 32'({ifc.awready, ifc.wready}), 32'h0);
            @(negedge clk);
        end
        ifc.bready = 1;
        @(negedge clk);
        check("stall.bdone", 32'(ifc.bvalid), 32'h0);
        check("stall.awready_back", 32'(ifc.awready), 32'h1);
        check("stall.one_update", 32'(bv_rises - bv0), 32'h1);
        check_reg("stall.da", 32'h48);

        // Randomized register traffic.
        for (int i = 0; i < 80; i++) begin
            op  = $urandom_range(0, 9);
            sel = $urandom_range(0, 4);
            case (sel)
                0: ofs = 8'h30;
                1: ofs = 8'h34;
                2: ofs = 8'h48;
                3: ofs = 8'h58;
                default: ofs = ($urandom_range(0, 1) == 0) ? 8'h40 : 8'hFC;
            endcase
            hi   = $urandom();
            addr = {hi[31:8], ofs};
            data = $urandom();
            if (ofs == 8'h30) data[0] = ($urandom_range(0, 3) != 0);
            if (ofs == 8'h58 && $urandom_range(0, 3) == 0) data = 32'h0;
            strb = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            if (op < 5) axi_write(addr, data, strb, $urandom_range(0, 5) == 0);
            else if (op < 7) pulse_done();
            else check_reg("rnd.rd", addr);
            check_status("rnd");
        end

        // Reset while a read response is pending.
        axi_write(32'h48, 32'h5A5A_5A5A, 4'hF, 0);
        @(negedge clk);
        ifc.araddr = 32'h48; ifc.arvalid = 1; ifc.rready = 0;
        n = 0;
        while (!ifc.arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ifc.arvalid = 0;
        repeat (2) @(negedge clk);
        check("pend.rvalid", 32'(ifc.rvalid), 32'h1);
        check("pend.rdata", ifc.rdata, 32'h5A5A_5A5A);
        rst_n = 0;
        #1;
        check("mid_rst.rvalid", 32'(ifc.rvalid), 32'h0);
        check("mid_rst.outputs", 32'({transfer_start, busy, irq, ifc.bvalid}), 32'h0);
        @(negedge clk);
        rst_n = 1;
        ifc.rready = 1;
        m_reset();
        check_reg("post_rst.cr", 32'h30);
        check_reg("post_rst.sr", 32'h34);
        check_reg("post_rst.da", 32'h48);
        check_reg("post_rst.len", 32'h58);
        check_status("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
